// File: rtl/cache_pkg.sv
// Shared types and default widths for the data-cache sequencing controller.
package cache_pkg;

  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned TAG_W    = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COMPARE  = 3'd1,
    MEM_WAIT = 3'd2,
    WRITE    = 3'd3,
    RECHECK  = 3'd4,
    DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/cache_controller_if.sv
// Request, datapath-control and statistics bundle between requester/datapath and controller.
interface cache_controller_if #(
  parameter int unsigned ADDR_W   = cache_pkg::ADDR_W,
  parameter int unsigned OFFSET_W = cache_pkg::OFFSET_W,
  parameter int unsigned CNT_W    = cache_pkg::CNT_W
);

  logic                req;
  logic [ADDR_W-1:0]   req_addr;
  logic                cache_valid;
  logic                is_wanted_data;
  logic                main_mem_ready;
  logic [ADDR_W-1:0]   address;
  logic [OFFSET_W-1:0] C_offset;
  logic                C_main_mem_miss;
  logic                C_write_cache;
  logic                busy;
  logic                done;
  logic                was_hit;
  logic [CNT_W-1:0]    hit_count;
  logic [CNT_W-1:0]    miss_count;

  modport master (
    output req, req_addr, cache_valid, is_wanted_data, main_mem_ready,
    input  address, C_offset, C_main_mem_miss, C_write_cache,
           busy, done, was_hit, hit_count, miss_count
  );

  modport slave (
    input  req, req_addr, cache_valid, is_wanted_data, main_mem_ready,
    output address, C_offset, C_main_mem_miss, C_write_cache,
           busy, done, was_hit, hit_count, miss_count
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = cache_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, increment only below the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/cache_controller.sv
// Read-miss sequencer: probe, 4-word block fill from main memory, re-probe, report.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W   = cache_pkg::ADDR_W,
  parameter int unsigned OFFSET_W = cache_pkg::OFFSET_W,
  parameter int unsigned CNT_W    = cache_pkg::CNT_W
) (
  input logic               clk,
  input logic               rst,
  cache_controller_if.slave bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic                was_hit_q, was_hit_d;
  logic                fill_err_q, fill_err_d;

  logic [ADDR_W-1:0]   address_q, address_d;
  logic [OFFSET_W-1:0] c_offset_q, c_offset_d;
  logic                mem_miss_q, mem_miss_d;
  logic                write_cache_q, write_cache_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                hit_c;
  logic                hit_inc_c;
  logic                miss_inc_c;
  logic [ADDR_W-1:0]   blk_addr_c;

  assign hit_c = bus.cache_valid & bus.is_wanted_data;

  // Next-state, offset counter, latched address and output decode of the next state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    was_hit_d  = was_hit_q;
    fill_err_d = fill_err_q;
    hit_inc_c  = 1'b0;
    miss_inc_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d  = bus.req_addr;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (hit_c) begin
          was_hit_d = 1'b1;
          hit_inc_c = 1'b1;
          state_d   = DONE;
        end else begin
          was_hit_d  = 1'b0;
          miss_inc_c = 1'b1;
          off_d      = '0;
          state_d    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (bus.main_mem_ready) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (off_q == '1) begin
          off_d   = '0;
          state_d = RECHECK;
        end else begin
          off_d   = off_q + OFFSET_W'(1);
          state_d = MEM_WAIT;
        end
      end
      RECHECK: begin
        if (!hit_c) begin
          fill_err_d = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    blk_addr_c    = {addr_d[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
    address_d     = '0;
    c_offset_d    = '0;
    mem_miss_d    = 1'b0;
    write_cache_d = 1'b0;
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    case (state_d)
      COMPARE, RECHECK: begin
        address_d = addr_d;
      end
      MEM_WAIT: begin
        address_d  = blk_addr_c;
        c_offset_d = off_d;
        mem_miss_d = 1'b1;
      end
      WRITE: begin
        address_d     = blk_addr_c;
        c_offset_d    = off_d;
        mem_miss_d    = 1'b1;
        write_cache_d = 1'b1;
      end
      default: begin
        address_d = '0;
      end
    endcase
  end

  // State, control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      off_q         <= '0;
      was_hit_q     <= 1'b0;
      fill_err_q    <= 1'b0;
      address_q     <= '0;
      c_offset_q    <= '0;
      mem_miss_q    <= 1'b0;
      write_cache_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      off_q         <= off_d;
      was_hit_q     <= was_hit_d;
      fill_err_q    <= fill_err_d;
      address_q     <= address_d;
      c_offset_q    <= c_offset_d;
      mem_miss_q    <= mem_miss_d;
      write_cache_q <= write_cache_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // First-probe hit statistics.
  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (hit_inc_c),
    .count (bus.hit_count)
  );

  // First-probe miss statistics.
  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (miss_inc_c),
    .count (bus.miss_count)
  );

  assign bus.address         = address_q;
  assign bus.C_offset        = c_offset_q;
  assign bus.C_main_mem_miss = mem_miss_q;
  assign bus.C_write_cache   = write_cache_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.was_hit         = was_hit_q;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller; a narrow-counter instance exercises saturation.
module tb_cache_controller;

  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned SCNT_W   = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cache_controller_if #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W))  bus ();
  cache_controller_if #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .CNT_W(SCNT_W)) sbus ();

  cache_controller #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cache_controller #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .CNT_W(SCNT_W)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 1'b0; bus.req_addr = '0; bus.cache_valid = 1'b0;
    bus.is_wanted_data = 1'b0; bus.main_mem_ready = 1'b0;
    sbus.req = 1'b0; sbus.req_addr = '0; sbus.cache_valid = 1'b0;
    sbus.is_wanted_data = 1'b0; sbus.main_mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.was_hit} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got busy/done/was_hit=%b want 000", {bus.busy, bus.done, bus.was_hit});
    end
    checks++;
    if ({bus.C_main_mem_miss, bus.C_write_cache, bus.C_offset} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got miss/wr/off=%b want 0000", {bus.C_main_mem_miss, bus.C_write_cache, bus.C_offset});
    end
    checks++;
    if (bus.address !== 15'h0000) begin
      errors++;
      $display("FAIL reset_address: got %h want 0000", bus.address);
    end
    checks++;
    if ({bus.hit_count, bus.miss_count} !== 32'h0) begin
      errors++;
      $display("FAIL reset_counters: got hit=%0d miss=%0d want 0 0", bus.hit_count, bus.miss_count);
    end
  endtask

  task automatic test_hit();
    int cyc;
    int got;
    int wr;
    bus.cache_valid = 1'b1; bus.is_wanted_data = 1'b1; bus.main_mem_ready = 1'b0;
    bus.req = 1'b1; bus.req_addr = 15'h1234;
    tick();
    bus.req = 1'b0;
    cyc = 1; got = -1; wr = 0;
    checks++;
    if (bus.address !== 15'h1234 || bus.C_offset !== 2'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL hit_compare_drive: got addr=%h off=%0d busy=%b want 1234 0 1", bus.address, bus.C_offset, bus.busy);
    end
    while (got < 0 && cyc < 20) begin
      if (bus.C_write_cache) wr++;
      if (bus.done) got = cyc;
      else begin tick(); cyc++; end
    end
    checks++;
    if (got !== 2) begin
      errors++;
      $display("FAIL hit_latency: got done cycle %0d want 2", got);
    end
    checks++;
    if (bus.was_hit !== 1'b1 || bus.hit_count !== 16'd1) begin
      errors++;
      $display("FAIL hit_stats: got was_hit=%b hit_count=%0d want 1 1", bus.was_hit, bus.hit_count);
    end
    checks++;
    if (wr !== 0) begin
      errors++;
      $display("FAIL hit_no_write: got %0d write strobes want 0", wr);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL hit_back_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_miss();
    int cyc;
    int got;
    int widx;
    bus.cache_valid = 1'b0; bus.is_wanted_data = 1'b0; bus.main_mem_ready = 1'b1;
    bus.req = 1'b1; bus.req_addr = 15'h0ABE;
    tick();
    bus.req = 1'b0;
    cyc = 1; got = -1; widx = 0;
    while (got < 0 && cyc < 40) begin
      if (bus.C_main_mem_miss) begin
        checks++;
        if (bus.address !== 15'h0ABC || bus.C_offset !== 2'(widx)) begin
          errors++;
          $display("FAIL miss_fill_drive: cycle %0d got addr=%h off=%0d want 0abc %0d", cyc, bus.address, bus.C_offset, widx);
        end
      end
      if (bus.C_write_cache) widx++;
      if (bus.done) got = cyc;
      else begin tick(); cyc++; end
    end
    checks++;
    if (got !== 11) begin
      errors++;
      $display("FAIL miss_latency: got done cycle %0d want 11", got);
    end
    checks++;
    if (widx !== 4) begin
      errors++;
      $display("FAIL miss_write_count: got %0d want 4", widx);
    end
    checks++;
    if (bus.miss_count !== 16'd1 || bus.hit_count !== 16'd1 || bus.was_hit !== 1'b0) begin
      errors++;
      $display("FAIL miss_stats: got miss=%0d hit=%0d was_hit=%b want 1 1 0", bus.miss_count, bus.hit_count, bus.was_hit);
    end
    tick();
  endtask

  task automatic test_slow_miss();
    int  cyc;
    int  got;
    int  wr;
    logic exp_miss;
    logic exp_wr;
    bus.cache_valid = 1'b0; bus.is_wanted_data = 1'b0; bus.main_mem_ready = 1'b0;
    bus.req = 1'b1; bus.req_addr = 15'h0100;
    tick();
    bus.req = 1'b0;
    cyc = 1; got = -1; wr = 0;
    while (got < 0 && cyc < 60) begin
      exp_miss = (cyc >= 2 && cyc <= 21);
      exp_wr   = (cyc == 6 || cyc == 11 || cyc == 16 || cyc == 21);
      checks++;
      if (bus.C_main_mem_miss !== exp_miss || bus.C_write_cache !== exp_wr) begin
        errors++;
        $display("FAIL slow_ctrl: cycle %0d got miss=%b wr=%b want %b %b", cyc, bus.C_main_mem_miss, bus.C_write_cache, exp_miss, exp_wr);
      end
      if (bus.C_write_cache) wr++;
      // Ready in COMPARE (1) and RECHECK (22) must be ignored.
      bus.main_mem_ready = (cyc == 1 || cyc == 5 || cyc == 10 || cyc == 15 || cyc == 20 || cyc == 22);
      if (bus.done) got = cyc;
      else begin tick(); cyc++; end
    end
    bus.main_mem_ready = 1'b0;
    checks++;
    if (got !== 23) begin
      errors++;
      $display("FAIL slow_latency: got done cycle %0d want 23", got);
    end
    checks++;
    if (wr !== 4 || bus.miss_count !== 16'd2) begin
      errors++;
      $display("FAIL slow_counts: got writes=%0d miss=%0d want 4 2", wr, bus.miss_count);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int   ndone;
    logic exp_done;
    bus.cache_valid = 1'b1; bus.is_wanted_data = 1'b1; bus.main_mem_ready = 1'b0;
    bus.req = 1'b1; bus.req_addr = 15'h0010;
    ndone = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      exp_done = (cyc == 2 || cyc == 5 || cyc == 8);
      checks++;
      if (bus.done !== exp_done) begin
        errors++;
        $display("FAIL b2b_done: cycle %0d got %b want %b", cyc, bus.done, exp_done);
      end
      if (bus.done) ndone++;
      if (cyc == 8) bus.req = 1'b0;
    end
    checks++;
    if (ndone !== 3 || bus.hit_count !== 16'd4) begin
      errors++;
      $display("FAIL b2b_counts: got dones=%0d hit=%0d want 3 4", ndone, bus.hit_count);
    end
  endtask

  task automatic test_req_ignored();
    int   ndone;
    logic exp_done;
    bus.cache_valid = 1'b0; bus.is_wanted_data = 1'b0; bus.main_mem_ready = 1'b1;
    bus.req = 1'b1; bus.req_addr = 15'h7FF3;
    ndone = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      bus.req = (cyc == 3 || cyc == 7 || cyc == 10);
      exp_done = (cyc == 11);
      checks++;
      if (bus.done !== exp_done) begin
        errors++;
        $display("FAIL ignore_done: cycle %0d got %b want %b", cyc, bus.done, exp_done);
      end
      if (bus.done) ndone++;
      if (bus.C_main_mem_miss) begin
        checks++;
        if (bus.address !== 15'h7FF0) begin
          errors++;
          $display("FAIL ignore_address: cycle %0d got %h want 7ff0", cyc, bus.address);
        end
      end
    end
    bus.req = 1'b0;
    checks++;
    if (ndone !== 1 || bus.miss_count !== 16'd3) begin
      errors++;
      $display("FAIL ignore_counts: got dones=%0d miss=%0d want 1 3", ndone, bus.miss_count);
    end
  endtask

  task automatic test_reset_midfill();
    int wr;
    bus.cache_valid = 1'b0; bus.is_wanted_data = 1'b0; bus.main_mem_ready = 1'b1;
    bus.req = 1'b1; bus.req_addr = 15'h0ABE;
    tick();
    bus.req = 1'b0;
    for (int cyc = 2; cyc <= 6; cyc++) tick();
    checks++;
    if (bus.C_offset !== 2'd2 || bus.C_main_mem_miss !== 1'b1 || bus.C_write_cache !== 1'b0) begin
      errors++;
      $display("FAIL midfill_pre: got off=%0d miss=%b wr=%b want 2 1 0", bus.C_offset, bus.C_main_mem_miss, bus.C_write_cache);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.was_hit, bus.C_main_mem_miss, bus.C_write_cache, bus.C_offset} !== 7'b0) begin
      errors++;
      $display("FAIL midfill_outputs: got busy/done/hit/miss/wr/off=%b want 0000000",
               {bus.busy, bus.done, bus.was_hit, bus.C_main_mem_miss, bus.C_write_cache, bus.C_offset});
    end
    checks++;
    if (bus.address !== 15'h0 || bus.hit_count !== 16'd0 || bus.miss_count !== 16'd0) begin
      errors++;
      $display("FAIL midfill_state: got addr=%h hit=%0d miss=%0d want 0000 0 0", bus.address, bus.hit_count, bus.miss_count);
    end
    wr = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.C_write_cache || bus.busy) wr++;
    end
    checks++;
    if (wr !== 0) begin
      errors++;
      $display("FAIL midfill_quiet: got %0d active cycles want 0", wr);
    end
  endtask

  task automatic test_saturation();
    int n;
    int cyc;
    sbus.cache_valid = 1'b1; sbus.is_wanted_data = 1'b1;
    sbus.req = 1'b1; sbus.req_addr = 15'h0042;
    n = 0; cyc = 0;
    while (n < 16 && cyc < 200) begin
      tick();
      cyc++;
      if (sbus.done) begin
        n++;
        if (n == 15) begin
          checks++;
          if (sbus.hit_count !== 4'hF) begin
            errors++;
            $display("FAIL sat_reach_max: got %0d want 15", sbus.hit_count);
          end
        end
      end
    end
    sbus.req = 1'b0;
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL sat_timeout: got %0d dones want 16", n);
    end
    checks++;
    if (sbus.hit_count !== 4'hF || sbus.miss_count !== 4'h0) begin
      errors++;
      $display("FAIL sat_hold: got hit=%0d miss=%0d want 15 0", sbus.hit_count, sbus.miss_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_hit();
    test_miss();
    test_slow_miss();
    test_back_to_back();
    test_req_ignored();
    test_reset_midfill();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
